boid_frame_scheduler: RTL and testbench

BOID_FRAME_SCHEDULER -- requirements
Module: boid_frame_scheduler

---
 rtl/boid_frame_scheduler.sv | 134 +++++++++++++
 tb/tb_boid_frame_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boid_frame_scheduler.sv
// Per-frame boid pass: request each boid's update from the shared engine, then
// erase its old pixel and draw its new one through a valid/ready pixel port.
module boid_frame_scheduler #(
  parameter int unsigned NUM_BOIDS  = 8,
  parameter int unsigned IDX_W      = 8,
  parameter logic [7:0]  BOID_COLOR = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  output logic             upd_req,
  output logic [IDX_W-1:0] upd_idx,
  input  logic             upd_ack,
  input  logic [31:0]      upd_x,
  input  logic [31:0]      upd_y,
  input  logic [31:0]      upd_px,
  input  logic [31:0]      upd_py,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [9:0]       pix_x,
  output logic [8:0]       pix_y,
  output logic [7:0]       pix_color,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ERASE,
    S_DRAW,
    S_NEXT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  // Only the integer halves of the positions are ever used, so only those are held.
  logic [15:0]      r_x;
  logic [15:0]      r_y;
  logic [15:0]      r_px;
  logic [15:0]      r_py;
  logic             r_frame_done;
  logic             r_overrun;

  logic             w_last;
  logic             w_erase_clip;
  logic             w_draw_clip;
  logic             w_draw_done;
  logic             w_unused_frac;

  assign w_last        = (r_idx == IDX_W'(NUM_BOIDS - 1));
  assign w_erase_clip  = (r_px >= 16'd640) || (r_py >= 16'd480);
  assign w_draw_clip   = (r_x  >= 16'd640) || (r_y  >= 16'd480);
  assign w_draw_done   = (r_state == S_DRAW) && (w_draw_clip || pix_ready);
  assign w_unused_frac = ^{upd_x[15:0], upd_y[15:0], upd_px[15:0], upd_py[15:0]};

  assign upd_idx    = r_idx;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

  always_comb begin
    w_next    = r_state;
    upd_req   = 1'b0;
    pix_valid = 1'b0;
    pix_x     = '0;
    pix_y     = '0;
    pix_color = '0;
    unique case (r_state)
      S_IDLE: begin
        if (frame_start) w_next = S_REQ;
      end
      S_REQ: begin
        upd_req = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        if (upd_ack) w_next = S_ERASE;
      end
      S_ERASE: begin
        // An off-screen coordinate skips the command as if it had been accepted.
        pix_valid = !w_erase_clip;
        pix_x     = r_px[9:0];
        pix_y     = r_py[8:0];
        pix_color = 8'h00;
        if (w_erase_clip || pix_ready) w_next = S_DRAW;
      end
      S_DRAW: begin
        pix_valid = !w_draw_clip;
        pix_x     = r_x[9:0];
        pix_y     = r_y[8:0];
        pix_color = BOID_COLOR;
        if (w_draw_done) w_next = S_NEXT;
      end
      S_NEXT: begin
        w_next = w_last ? S_IDLE : S_REQ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_px         <= '0;
      r_py         <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && frame_start) begin
        r_idx <= '0;
      end else if (r_state == S_NEXT && !w_last) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (r_state == S_WAIT && upd_ack) begin
        r_x  <= upd_x[31:16];
        r_y  <= upd_y[31:16];
        r_px <= upd_px[31:16];
        r_py <= upd_py[31:16];
      end
      // Registered off the final draw handshake so it coincides with NEXT.
      r_frame_done <= w_draw_done && w_last;
      if (frame_start && busy) r_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Scoreboard bench for boid_frame_scheduler: expected update indices and pixel
// commands are queued by the stimulus and popped by a negedge monitor.
module tb_boid_frame_scheduler;
  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        upd_req;
  logic [7:0]  upd_idx;
  logic        upd_ack = 1'b0;
  logic [31:0] upd_x = '0, upd_y = '0, upd_px = '0, upd_py = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [7:0]  pix_color;
  logic        busy, frame_done, overrun;

  always #5 clk = ~clk;

  boid_frame_scheduler #(.NUM_BOIDS(NB), .IDX_W(8), .BOID_COLOR(8'hFF)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .upd_req(upd_req), .upd_idx(upd_idx), .upd_ack(upd_ack),
    .upd_x(upd_x), .upd_y(upd_y), .upd_px(upd_px), .upd_py(upd_py),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          eng_skip = -1;
  logic [7:0]  q_req[$];
  logic [26:0] q_pix[$];
  logic [31:0] tx[NB], ty[NB], tpx[NB], tpy[NB];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_pix(input int x, input int y, input logic [7:0] c);
    q_pix.push_back({10'(x), 9'(y), c});
  endtask

  task automatic exp_reqs(input int n);
    for (int i = 0; i < n; i++) q_req.push_back(8'(i));
  endtask

  task automatic load_base();
    tx[0] = 32'h00B4_0000; ty[0] = 32'h00C8_0000; tpx[0] = 32'h00B0_0000; tpy[0] = 32'h00C4_0000;
    tx[1] = 32'h000A_8000; ty[1] = 32'h0014_FFFF; tpx[1] = 32'h0009_0000; tpy[1] = 32'h0013_0000;
    tx[2] = 32'h027F_0000; ty[2] = 32'h01DF_0000; tpx[2] = 32'h0000_0000; tpy[2] = 32'h0000_0000;
    tx[3] = 32'h0140_0000; ty[3] = 32'h00F0_0000; tpx[3] = 32'h013F_0000; tpy[3] = 32'h00EF_0000;
  endtask

  task automatic exp_base_frame();
    exp_reqs(4);
    exp_pix(176, 196, 8'h00); exp_pix(180, 200, 8'hFF);
    exp_pix(9,   19,  8'h00); exp_pix(10,  20,  8'hFF);
    exp_pix(0,   0,   8'h00); exp_pix(639, 479, 8'hFF);
    exp_pix(319, 239, 8'h00); exp_pix(320, 240, 8'hFF);
  endtask

  task automatic start_frame(output int t0);
    frame_start = 1'b1;
    t0 = cyc;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(output int t1);
    t1 = -1;
    for (int k = 0; k < 300; k++) begin
      if (frame_done) begin
        t1 = cyc;
        break;
      end
      tick();
    end
    if (t1 < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_done_timeout: got none expected pulse within 300 cycles");
    end
  endtask

  // Engine model: acknowledges one cycle after each request with table data.
  initial begin
    forever begin
      tick();
      if (upd_req && int'(upd_idx) != eng_skip) begin
        automatic int i = int'(upd_idx);
        tick();
        upd_x = tx[i]; upd_y = ty[i]; upd_px = tpx[i]; upd_py = tpy[i];
        upd_ack = 1'b1;
        tick();
        upd_ack = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (upd_req) begin
        n_checks++;
        if (q_req.size() == 0) begin
          n_fail++;
          $display("FAIL upd_req_unexpected: got idx %0d expected no request", upd_idx);
        end else begin
          automatic logic [7:0] e = q_req.pop_front();
          if (upd_idx !== e) begin
            n_fail++;
            $display("FAIL upd_idx: got %0d expected %0d", upd_idx, e);
          end
        end
      end
      if (pix_valid && pix_ready) begin
        n_checks++;
        if (q_pix.size() == 0) begin
          n_fail++;
          $display("FAIL pix_unexpected: got (%0d,%0d,%0h) expected no command", pix_x, pix_y, pix_color);
        end else begin
          automatic logic [26:0] e = q_pix.pop_front();
          if ({pix_x, pix_y, pix_color} !== e) begin
            n_fail++;
            $display("FAIL pix_cmd: got (%0d,%0d,%0h) expected (%0d,%0d,%0h)",
                     pix_x, pix_y, pix_color, e[26:17], e[16:8], e[7:0]);
          end
        end
      end
      if (frame_done) n_done++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1, "stopped");
  end

  initial begin
    int t0, t1, d0;
    load_base();
    tick(); tick(); tick();
    chk("rst_upd_req", upd_req, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_upd_idx", upd_idx, 0);
    reset = 1'b0;
    tick();

    // Nominal four-boid pass
    exp_base_frame();
    start_frame(t0);
    chk("busy_in_pass", busy, 1);
    wait_done(t1);
    chk("frame_len_nominal", t1 - t0, 20);
    tick();
    chk("frame_done_one_cycle", frame_done, 0);
    chk("busy_after_pass", busy, 0);
    chk("single_done_nominal", n_done, 1);

    // Pixel writer stalls during the first erase
    exp_base_frame();
    pix_ready = 1'b0;
    start_frame(t0);
    for (int k = 0; k < 20 && !pix_valid; k++) tick();
    for (int k = 0; k < 10; k++) begin
      chk("stall_hold", {pix_valid, pix_x, pix_y, pix_color}, {1'b1, 10'd176, 9'd196, 8'h00});
      tick();
    end
    pix_ready = 1'b1;
    chk("stall_release_erase", {pix_valid, pix_x, pix_y, pix_color}, {1'b1, 10'd176, 9'd196, 8'h00});
    tick();
    chk("stall_then_draw", {pix_valid, pix_x, pix_y, pix_color}, {1'b1, 10'd180, 9'd200, 8'hFF});
    wait_done(t1);
    tick();

    // Second frame_start mid-pass
    d0 = n_done;
    exp_base_frame();
    start_frame(t0);
    repeat (7) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("overrun_set", overrun, 1);
    wait_done(t1);
    chk("frame_len_overrun", t1 - t0, 20);
    repeat (3) tick();
    chk("single_done_overrun", n_done - d0, 1);
    chk("busy_after_overrun", busy, 0);
    exp_base_frame();
    start_frame(t0);
    wait_done(t1);
    tick();
    chk("overrun_sticky", overrun, 1);

    // Off-screen coordinates suppress commands without stalling
    tx[1] = 32'h0280_0000;
    tpx[2] = 32'h0280_0000; ty[2] = 32'h01E0_0000;
    exp_reqs(4);
    exp_pix(176, 196, 8'h00); exp_pix(180, 200, 8'hFF);
    exp_pix(9, 19, 8'h00);
    exp_pix(319, 239, 8'h00); exp_pix(320, 240, 8'hFF);
    start_frame(t0);
    wait_done(t1);
    chk("frame_len_clamped", t1 - t0, 20);
    tick();
    load_base();

    // Reset while waiting on boid 2, then a stale acknowledge
    eng_skip = 2;
    exp_reqs(3);
    exp_pix(176, 196, 8'h00); exp_pix(180, 200, 8'hFF);
    exp_pix(9, 19, 8'h00);    exp_pix(10, 20, 8'hFF);
    start_frame(t0);
    for (int k = 0; k < 40 && !(upd_req && upd_idx == 8'd2); k++) tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    upd_x = tx[2]; upd_y = ty[2]; upd_px = tpx[2]; upd_py = tpy[2];
    upd_ack = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_upd_idx", upd_idx, 0);
    tick();
    upd_ack = 1'b0;
    chk("stale_ack_pix_valid", pix_valid, 0);
    repeat (5) tick();
    chk("idle_after_rst_busy", busy, 0);
    chk("idle_after_rst_frame_done", frame_done, 0);
    eng_skip = -1;
    exp_base_frame();
    start_frame(t0);
    wait_done(t1);
    chk("frame_len_after_rst", t1 - t0, 20);
    repeat (3) tick();
    chk("q_req_drained", q_req.size(), 0);
    chk("q_pix_drained", q_pix.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
